// File: rtl/queue_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for queue_fifo_ctrl.
// Error-flag ports exist only when QUEUE_ERR_FLAG_EN is defined.
interface queue_fifo_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              Push_i;
    logic [DATA_W-1:0] PushData_i;
    logic              Pop_i;
    logic [DATA_W-1:0] PopData_o;
    logic              Full_o;
    logic              Empty_o;
    logic              AlmostFull_o;
    logic [ADDR_W:0]   Count_o;
`ifdef QUEUE_ERR_FLAG_EN
    logic              Overflow_o;
    logic              Underflow_o;
`endif

    // Driven by the producer/consumer pair sitting around the queue.
    modport master (
        output Push_i, PushData_i, Pop_i,
        input  PopData_o, Full_o, Empty_o, AlmostFull_o, Count_o
`ifdef QUEUE_ERR_FLAG_EN
        , input Overflow_o, Underflow_o
`endif
    );

    modport slave (
        input  Push_i, PushData_i, Pop_i,
        output PopData_o, Full_o, Empty_o, AlmostFull_o, Count_o
`ifdef QUEUE_ERR_FLAG_EN
        , output Overflow_o, Underflow_o
`endif
    );
endinterface

// File: rtl/queue_fifo_ctrl.sv
// Circular-buffer FWFT queue; occupancy = wr_ptr - rd_ptr via a ripple full-subtractor chain.
// Optional sticky overflow/underflow flags are built when QUEUE_ERR_FLAG_EN is defined.
module queue_fifo_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6
) (
    input  logic            Clk_i,
    input  logic            Rst_i,
    queue_fifo_ctrl_if.slave q
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_CNT   = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   borrow;
    logic              full;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;

    // Bit-serial borrow chain; the top cell's borrow-out is simply not built,
    // which gives the modular difference that absorbs pointer wrap.
    assign borrow[0] = 1'b0;
    for (genvar i = 0; i <= ADDR_W; i++) begin : g_sub
        assign count[i] = wr_ptr[i] ^ rd_ptr[i] ^ borrow[i];
        if (i < ADDR_W) begin : g_bout
            assign borrow[i+1] = (~wr_ptr[i] & rd_ptr[i])
                               | (~(wr_ptr[i] ^ rd_ptr[i]) & borrow[i]);
        end
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    assign q.Count_o      = count;
    assign q.Full_o       = full;
    assign q.Empty_o      = empty;
    assign q.AlmostFull_o = (count >= AF_CNT);
    assign q.PopData_o    = mem[rd_ptr[ADDR_W-1:0]];

    assign push_ok = q.Push_i & ~full;
    assign pop_ok  = q.Pop_i & ~empty;

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is never cleared; reset only discards words by rewinding pointers.
    always_ff @(posedge Clk_i) begin
        if (push_ok && !Rst_i) begin
            mem[wr_ptr[ADDR_W-1:0]] <= q.PushData_i;
        end
    end

`ifdef QUEUE_ERR_FLAG_EN
    logic overflow;
    logic underflow;

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (q.Push_i && full) overflow  <= 1'b1;
            if (q.Pop_i && empty) underflow <= 1'b1;
        end
    end

    assign q.Overflow_o  = overflow;
    assign q.Underflow_o = underflow;
`endif

endmodule
